mult_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one pipelined integer multiplier (intMult, fixed LAT-cycle

---
 rtl/mult_rr_scheduler_if.sv | 31 +++
 rtl/mult_rr_scheduler.sv | 72 +++++++
 tb/tb_mult_rr_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_scheduler_if.sv
// Bundle between the requesters, the shared multiplier and the round-robin scheduler.
// The scheduler takes the slave view; whoever owns the requesters and the multiplier takes the master view.
interface mult_rr_scheduler_if #(
   parameter int DATA_W  = 64,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic                      hold;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [DATA_W-1:0]         mult_a;
   logic [DATA_W-1:0]         mult_b;
   logic [2*DATA_W-1:0]       mult_c;
   logic                      res_valid;
   logic [ID_W-1:0]           res_id;
   logic [2*DATA_W-1:0]       res_c;
   logic                      busy;

   modport slave (
      input  hold, req_valid, req_a, req_b, mult_c,
      output req_ready, mult_a, mult_b, res_valid, res_id, res_c, busy
   );

   modport master (
      output hold, req_valid, req_a, req_b, mult_c,
      input  req_ready, mult_a, mult_b, res_valid, res_id, res_c, busy
   );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin sharing of one fixed-latency pipelined multiplier among NUM_REQ requesters.
// The requester ID rides a LAT-deep tag pipeline alongside the multiplier so each product comes back tagged.
module mult_rr_scheduler #(
   parameter int DATA_W  = 64,
   parameter int NUM_REQ = 4,
   parameter int LAT     = 3
) (
   input logic                clk,
   input logic                reset,
   mult_rr_scheduler_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] grant_idx;
   logic            grant_vld;
   logic [LAT-1:0]  vld_q;
   logic [ID_W-1:0] id_q [LAT];

   // Search order starts at ptr and wraps; reset low or hold blocks every grant.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (reset && !bus.hold) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && bus.req_valid[cand]) begin
               grant_vld = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      bus.mult_a    = '0;
      bus.mult_b    = '0;
      ptr_d         = ptr_q;
      if (grant_vld) begin
         bus.req_ready[grant_idx] = 1'b1;
         bus.mult_a = bus.req_a[grant_idx*DATA_W +: DATA_W];
         bus.mult_b = bus.req_b[grant_idx*DATA_W +: DATA_W];
         ptr_d      = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q <= '0;
         vld_q <= '0;
         for (int k = 0; k < LAT; k++) id_q[k] <= '0;
      end else begin
         ptr_q    <= ptr_d;
         vld_q[0] <= grant_vld;
         id_q[0]  <= grant_idx;
         for (int k = 1; k < LAT; k++) begin
            vld_q[k] <= vld_q[k-1];
            id_q[k]  <= id_q[k-1];
         end
      end
   end

   // Last tag stage lines up with the multiplier output; busy ignores the grant being made this cycle.
   assign bus.res_valid = vld_q[LAT-1];
   assign bus.res_id    = id_q[LAT-1];
   assign bus.res_c     = bus.mult_c;
   assign bus.busy      = |vld_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a behavioural LAT-cycle multiplier attached.
module tb_mult_rr_scheduler;
   localparam int DATA_W  = 64;
   localparam int NUM_REQ = 4;
   localparam int LAT     = 3;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mult_rr_scheduler_if #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) bus ();

   mult_rr_scheduler #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stand-in: cleared by the same reset, product appears LAT edges after the operands.
   logic [2*DATA_W-1:0] mpipe [LAT];
   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < LAT; k++) mpipe[k] <= '0;
      end else begin
         mpipe[0] <= {{DATA_W{1'b0}}, bus.mult_a} * {{DATA_W{1'b0}}, bus.mult_b};
         for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
      end
   end
   assign bus.mult_c = mpipe[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_ops(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      bus.req_a[i*DATA_W +: DATA_W] = a;
      bus.req_b[i*DATA_W +: DATA_W] = b;
   endtask

   task automatic apply_reset();
      reset         = 1'b0;
      bus.hold      = 1'b0;
      bus.req_valid = '0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.hold      = 1'b0;
      bus.req_valid = 4'b1111;
      mid();
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
      end
      tick();
      mid();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.res_id !== 2'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b id=%0d busy=%b expected 0 0 0",
                  bus.res_valid, bus.res_id, bus.busy);
      end
      tick();
      bus.req_valid = '0;
      reset = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      set_ops(0, 64'd3, 64'd5);
      bus.req_valid = 4'b0001;
      mid();
      checks++;
      if (bus.req_ready !== 4'b0001 || bus.mult_a !== 64'd3 || bus.mult_b !== 64'd5 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_grant: got ready=%b a=%0d b=%0d busy=%b expected 0001 3 5 0",
                  bus.req_ready, bus.mult_a, bus.mult_b, bus.busy);
      end
      tick();
      bus.req_valid = '0;
      for (int c = 1; c <= 4; c++) begin
         mid();
         checks++;
         if (bus.busy !== (c <= 3)) begin
            errors++;
            $display("FAIL single_busy c=%0d: got %b expected %b", c, bus.busy, (c <= 3));
         end
         if (c == 1) begin
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.mult_a !== 64'd0 || bus.mult_b !== 64'd0) begin
               errors++;
               $display("FAIL idle_outputs: got ready=%b a=%0d b=%0d expected 0000 0 0",
                        bus.req_ready, bus.mult_a, bus.mult_b);
            end
         end
         checks++;
         if (c == 3) begin
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_c !== 128'd15) begin
               errors++;
               $display("FAIL single_result: got valid=%b id=%0d c=%0d expected 1 0 15",
                        bus.res_valid, bus.res_id, bus.res_c);
            end
         end else if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_novalid c=%0d: got %b expected 0", c, bus.res_valid);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [2*DATA_W-1:0] prod [4] = '{128'd20, 128'd30, 128'd40, 128'd50};
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 64'(i + 2), 64'd10);
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 11; c++) begin
         if (c == 8) bus.req_valid = '0;
         mid();
         if (c < 8) begin
            checks++;
            if (bus.req_ready !== 4'(1 << (c % 4))) begin
               errors++;
               $display("FAIL b2b_grant c=%0d: got %b expected %b", c, bus.req_ready, 4'(1 << (c % 4)));
            end
         end
         if (c >= 3) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'((c - 3) % 4) || bus.res_c !== prod[(c - 3) % 4]) begin
               errors++;
               $display("FAIL b2b_result c=%0d: got valid=%b id=%0d c=%0d expected 1 %0d %0d",
                        c, bus.res_valid, bus.res_id, bus.res_c, (c - 3) % 4, prod[(c - 3) % 4]);
            end
         end
         tick();
      end
      mid();
      checks++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got busy=%b valid=%b expected 0 0", bus.busy, bus.res_valid);
      end
      tick();
   endtask

   task automatic test_max_operands();
      apply_reset();
      set_ops(2, {DATA_W{1'b1}}, {DATA_W{1'b1}});
      bus.req_valid = 4'b0100;
      mid();
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL max_grant: got %b expected 0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      mid();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 ||
          bus.res_c !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
         errors++;
         $display("FAIL max_product: got valid=%b id=%0d c=%h expected 1 2 fffffffffffffffe0000000000000001",
                  bus.res_valid, bus.res_id, bus.res_c);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [3:0]          exp_rdy [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      logic [1:0]          exp_id  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
      logic [2*DATA_W-1:0] exp_c   [4] = '{128'd42, 128'd81, 128'd42, 128'd81};
      apply_reset();
      set_ops(0, 64'd7, 64'd6);
      set_ops(2, 64'd9, 64'd9);
      bus.req_valid = 4'b0101;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) bus.req_valid = '0;
         mid();
         if (c < 4) begin
            checks++;
            if (bus.req_ready !== exp_rdy[c]) begin
               errors++;
               $display("FAIL wrap_grant c=%0d: got %b expected %b", c, bus.req_ready, exp_rdy[c]);
            end
         end
         if (c >= 3) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== exp_id[c-3] || bus.res_c !== exp_c[c-3]) begin
               errors++;
               $display("FAIL wrap_result c=%0d: got valid=%b id=%0d c=%0d expected 1 %0d %0d",
                        c, bus.res_valid, bus.res_id, bus.res_c, exp_id[c-3], exp_c[c-3]);
            end
         end
         tick();
      end
   endtask

   task automatic test_hold();
      logic [3:0] exp_rdy  [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
      logic       hold_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic       exp_rv   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0] exp_id   [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0};
      logic [2*DATA_W-1:0] exp_c [9] = '{128'd0, 128'd0, 128'd0, 128'd20, 128'd30,
                                         128'd0, 128'd0, 128'd40, 128'd0};
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 64'(i + 2), 64'd10);
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 9; c++) begin
         if (c < 5) bus.hold = hold_seq[c];
         else begin
            bus.hold      = 1'b0;
            bus.req_valid = '0;
         end
         mid();
         if (c < 5) begin
            checks++;
            if (bus.req_ready !== exp_rdy[c]) begin
               errors++;
               $display("FAIL hold_grant c=%0d: got %b expected %b", c, bus.req_ready, exp_rdy[c]);
            end
         end
         checks++;
         if (bus.res_valid !== exp_rv[c] || (exp_rv[c] && (bus.res_id !== exp_id[c] || bus.res_c !== exp_c[c]))) begin
            errors++;
            $display("FAIL hold_result c=%0d: got valid=%b id=%0d c=%0d expected %b %0d %0d",
                     c, bus.res_valid, bus.res_id, bus.res_c, exp_rv[c], exp_id[c], exp_c[c]);
         end
         if (c == 3 || c == 8) begin
            checks++;
            if (bus.busy !== (c == 3)) begin
               errors++;
               $display("FAIL hold_busy c=%0d: got %b expected %b", c, bus.busy, (c == 3));
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_flush();
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 64'(i + 2), 64'd10);
      bus.req_valid = 4'b1111;
      tick();
      tick();
      tick();
      reset         = 1'b0;
      bus.req_valid = '0;
      mid();
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL flush_ready: got %b expected 0000", bus.req_ready);
      end
      tick();
      reset         = 1'b1;
      bus.req_valid = 4'b1010;
      mid();
      checks++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL flush_state: got busy=%b ready=%b expected 0 0010", bus.busy, bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      for (int c = 5; c <= 7; c++) begin
         mid();
         checks++;
         if (c < 7 && bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped c=%0d: got valid=%b expected 0", c, bus.res_valid);
         end else if (c == 7 && (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_c !== 128'd30)) begin
            errors++;
            $display("FAIL flush_after: got valid=%b id=%0d c=%0d expected 1 1 30",
                     bus.res_valid, bus.res_id, bus.res_c);
         end
         tick();
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.hold      = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      tick();
      test_reset();
      test_single();
      test_back_to_back();
      test_max_operands();
      test_wrap();
      test_hold();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
